scanline_fetch_ctrl: RTL

- Line-buffer scheduler between the shared frame-pixel memory read port and the HDMI video timing generator.
- Prefetches each source row into a ping-pong line buffer during the previous display line.
- Serves RGB565 pixels to the timing generator with 2x horizontal and vertical upscaling.
- Arbitrates the single memory read port between line fetch (priority) and a CPU read requester.

---
 rtl/scanline_fetch_ctrl_pkg.sv | 19 +
 rtl/scanline_fetch_ctrl_if.sv | 31 +++
 rtl/scanline_fetch_ctrl_buf_dp.sv | 20 ++
 rtl/scanline_fetch_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/scanline_fetch_ctrl_pkg.sv
// rtl/scanline_fetch_ctrl_pkg.sv - shared types and default geometry for the scanline fetch controller
package scanline_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  localparam int H_DISP          = 640;
  localparam int DEF_SCALE_SHIFT = 1;
  localparam int DEF_LINE_W      = H_DISP >> DEF_SCALE_SHIFT;
  localparam int DEF_SRC_H       = 240;
  localparam int DEF_ADDR_W      = 17;
  localparam int RGB_W           = 16;
  localparam int MEM_DATA_W      = 16;
  localparam int XPOS_W          = 12;

endpackage

// File: rtl/scanline_fetch_ctrl_if.sv
// rtl/scanline_fetch_ctrl_if.sv - video timing, frame-memory and CPU read signals of the fetch controller
interface scanline_fetch_ctrl_if
  import scanline_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) ();
  logic                  frame_start;
  logic                  line_start;
  logic                  pixel_req;
  logic [XPOS_W-1:0]     pixel_xpos;
  logic [RGB_W-1:0]      video_rgb_565;
  logic                  mem_rd_en;
  logic [ADDR_W-1:0]     mem_addr;
  logic [MEM_DATA_W-1:0] mem_rdata;
  logic                  cpu_req;
  logic [ADDR_W-1:0]     cpu_addr;
  logic                  cpu_gnt;
  logic                  cpu_rvalid;
  logic [MEM_DATA_W-1:0] cpu_rdata;
  logic                  underrun;

  modport master (
    input  frame_start, line_start, pixel_req, pixel_xpos, mem_rdata, cpu_req, cpu_addr,
    output video_rgb_565, mem_rd_en, mem_addr, cpu_gnt, cpu_rvalid, cpu_rdata, underrun
  );

  modport slave (
    output frame_start, line_start, pixel_req, pixel_xpos, mem_rdata, cpu_req, cpu_addr,
    input  video_rgb_565, mem_rd_en, mem_addr, cpu_gnt, cpu_rvalid, cpu_rdata, underrun
  );
endinterface

// File: rtl/scanline_fetch_ctrl_buf_dp.sv
// rtl/scanline_fetch_ctrl_buf_dp.sv - ping-pong line buffer, simple dual-port RAM with registered read
module scanline_buf_dp #(
  parameter int COL_W  = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [COL_W:0]    i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [COL_W:0]    i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  // Address MSB selects the half; each half is padded to a power of two so no multiply is needed.
  logic [DATA_W-1:0] r_mem [2**(COL_W+1)];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/scanline_fetch_ctrl.sv
// rtl/scanline_fetch_ctrl.sv - prefetches source rows into a ping-pong buffer and serves 2x-upscaled pixels
module scanline_fetch_ctrl
  import scanline_fetch_ctrl_pkg::*;
#(
  parameter int LINE_W      = DEF_LINE_W,
  parameter int SRC_H       = DEF_SRC_H,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int SCALE_SHIFT = DEF_SCALE_SHIFT
) (
  input  logic                  pixel_clk,
  input  logic                  sys_rst,
  scanline_fetch_ctrl_if.master bus
);
  localparam int COL_W = $clog2(LINE_W);
  localparam int ROW_W = $clog2(SRC_H + 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(LINE_W);

  fetch_state_t           r_state;
  logic [COL_W-1:0]       r_col, r_col_d;
  logic [ADDR_W-1:0]      r_row_base, r_fetch_addr;
  logic [ROW_W-1:0]       r_src_row;
  logic [SCALE_SHIFT-1:0] r_disp_sub;
  logic r_wr_buf, r_disp_buf, r_swap_pend, r_fetch_rd, r_fetch_rd_d;
  logic r_underrun, r_cpu_rvalid, r_pix_valid;

  logic              w_line_ok, w_wrap, w_fetch_next, w_fetch_start, w_gnt, w_pix_in;
  logic [XPOS_W-1:0] w_src_col;
  logic [RGB_W-1:0]  w_buf_q;

  assign w_line_ok     = bus.line_start && !bus.frame_start && (r_src_row < ROW_W'(SRC_H));
  assign w_wrap        = w_line_ok && (r_disp_sub == '1);
  assign w_fetch_next  = w_wrap && ((int'(r_src_row) + 1) < SRC_H);
  assign w_fetch_start = bus.frame_start || w_fetch_next;
  assign w_gnt         = bus.cpu_req && !sys_rst && !w_fetch_start &&
                         (r_state == ST_IDLE || r_state == ST_DRAIN);
  assign w_src_col     = bus.pixel_xpos >> SCALE_SHIFT;
  assign w_pix_in      = bus.pixel_req && (w_src_col < XPOS_W'(LINE_W));

  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state      <= ST_IDLE;
      r_col        <= '0;
      r_col_d      <= '0;
      r_row_base   <= '0;
      r_fetch_addr <= '0;
      r_src_row    <= '0;
      r_disp_sub   <= '0;
      r_wr_buf     <= 1'b0;
      r_disp_buf   <= 1'b0;
      r_swap_pend  <= 1'b0;
      r_fetch_rd   <= 1'b0;
      r_fetch_rd_d <= 1'b0;
      r_underrun   <= 1'b0;
      r_cpu_rvalid <= 1'b0;
      r_pix_valid  <= 1'b0;
    end else begin
      r_fetch_rd_d <= r_fetch_rd;
      r_col_d      <= r_col;
      r_cpu_rvalid <= w_gnt;
      r_pix_valid  <= w_pix_in;
      if (bus.frame_start) begin
        r_src_row    <= '0;
        r_disp_sub   <= '0;
        r_row_base   <= '0;
        r_wr_buf     <= 1'b0;
        r_disp_buf   <= 1'b0;
        r_swap_pend  <= 1'b0;
        r_underrun   <= 1'b0;
        r_fetch_rd_d <= 1'b0;
        r_state      <= ST_FETCH;
        r_fetch_rd   <= 1'b1;
        r_col        <= '0;
        r_fetch_addr <= '0;
      end else begin
        case (r_state)
          ST_FETCH: begin
            if (r_col == COL_W'(LINE_W - 1)) begin
              r_state    <= ST_DRAIN;
              r_fetch_rd <= 1'b0;
            end else begin
              r_col        <= r_col + 1'b1;
              r_fetch_addr <= r_fetch_addr + 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
        if (w_line_ok) begin
          r_disp_sub <= r_disp_sub + SCALE_SHIFT'(1);
          // First line of a new source row: show the freshly filled half, or flag the late fetch.
          if (r_swap_pend) begin
            r_swap_pend <= 1'b0;
            if (r_state != ST_IDLE) begin
              r_underrun   <= 1'b1;
              r_state      <= ST_IDLE;
              r_fetch_rd   <= 1'b0;
              r_fetch_rd_d <= 1'b0;
            end else begin
              r_disp_buf <= r_wr_buf;
            end
          end
          if (w_wrap) begin
            r_src_row <= r_src_row + 1'b1;
            if (w_fetch_next) begin
              r_row_base   <= r_row_base + LINE_STEP;
              r_fetch_addr <= r_row_base + LINE_STEP;
              r_wr_buf     <= ~r_disp_buf;
              r_swap_pend  <= 1'b1;
              r_state      <= ST_FETCH;
              r_fetch_rd   <= 1'b1;
              r_fetch_rd_d <= 1'b0;
              r_col        <= '0;
            end
          end
        end
      end
    end
  end

  scanline_buf_dp #(.COL_W(COL_W), .DATA_W(RGB_W)) u_buf (
    .clk     (pixel_clk),
    .i_we    (r_fetch_rd_d),
    .i_waddr ({r_wr_buf, r_col_d}),
    .i_wdata (bus.mem_rdata),
    .i_raddr ({r_disp_buf, w_src_col[COL_W-1:0]}),
    .o_rdata (w_buf_q)
  );

  assign bus.mem_rd_en     = r_fetch_rd || w_gnt;
  assign bus.mem_addr      = r_fetch_rd ? r_fetch_addr : (w_gnt ? bus.cpu_addr : '0);
  assign bus.cpu_gnt       = w_gnt;
  assign bus.cpu_rvalid    = r_cpu_rvalid;
  assign bus.cpu_rdata     = r_cpu_rvalid ? bus.mem_rdata : '0;
  assign bus.underrun      = r_underrun;
  assign bus.video_rgb_565 = r_pix_valid ? w_buf_q : '0;
endmodule
